iterative_alu: RTL
==================

// Module: iterative_alu
// PURPOSE
//  Execution-side consumer of the 4-bit ALU Operation code produced by the ALU control decoder.
//  Latches operands on a start strobe. Simple ops finish in one cycle.
//  Shifts run bit-serially, one bit per cycle, so the datapath needs no barrel shifter.
//  Returns ALUResult/Zero with a one-cycle done pulse. Sits in the EX stage.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; shift amount = SrcB[$clog2(DATA_WIDTH)-1:0]
// PORTS
//  clk        in   1           clock; all state updates on rising edge
//  reset      in   1           reset, synchronous, active-low (0 = reset)
//  start      in   1           request; sampled only while busy=0
//  Operation  in   4           op code (table below); latched with start
//  SrcA       in   DATA_WIDTH  operand A; latched with start
//  SrcB       in   DATA_WIDTH  operand B / shift amount; latched with start
//  busy       out  1           1 while a shift is iterating; start ignored
//  done       out  1           one-cycle pulse: ALUResult/Zero valid
//  ALUResult  out  DATA_WIDTH  registered result; held until next completion
//  Zero       out  1           branch ops: condition true; otherwise ALUResult==0
// BEHAVIOUR
//  Op table:
//   0000 AND | 0001 XOR | 0011 OR | 0100 ADD | 0010 SUB
//   1001 SLL | 1100 SRL | 0111 SRA | 1110 SLT (signed, result 0/1) | 1010 LUI (result = B)
//   1000 BEQ | 0110 BNE | 1101 BLT (signed) | 0101 BGE (signed)
//   1011, 1111 reserved: ALUResult=0, Zero=1, latency 1
//  Branch ops: ALUResult = {0..., cond}; Zero = cond.
//  Arithmetic: ADD/SUB wrap modulo 2^DATA_WIDTH; no overflow flag.
//  FSM: IDLE, SHIFT.
//   IDLE & start=1, non-shift op or shamt=0:
//    - result/Zero registered at that edge; done=1 next cycle
//    - stay IDLE; latency 1
//   IDLE & start=1, shift op with shamt=k>0:
//    - latch A, op; counter=k; go SHIFT; busy=1
//   SHIFT, each edge:
//    - shift working reg 1 bit: SLL zero-fill, SRL zero-fill, SRA sign-fill
//    - decrement counter
//    - when counter==1: write result, done=1, busy=0, go IDLE
//   Shift latency = 1+k cycles from the start edge; max DATA_WIDTH.
//  Handshake:
//   - done is high exactly one cycle per accepted request
//   - start while busy=1 is dropped; no queueing
//   - start in the cycle done=1 is accepted (FSM already IDLE)
//   - Operation/SrcA/SrcB may change freely after the start edge
//  Reset (reset=0 at an edge, any state, incl. mid-shift):
//   - state=IDLE; busy=0, done=0, ALUResult=0, Zero=0; counter=0
//   - in-flight shift is discarded; no done pulse
// TESTING
//  ADD A=5 B=7 -> next cycle done=1, ALUResult=12, Zero=0, busy never 1
//  SUB A=3 B=5 -> ALUResult=0xFFFFFFFE; SUB A=9 B=9 -> ALUResult=0, Zero=1
//  SRA A=0x80000000 B=4:
//   - busy=1 for 4 cycles; done on cycle 5; ALUResult=0xF8000000
//   - start pulsed mid-shift is ignored
//  SLL A=1 B=0 -> latency 1, ALUResult=1
//  SLL A=1 B=31 -> done on cycle 32, ALUResult=0x80000000
//  BLT A=-1 B=1 -> Zero=1, ALUResult=1; BGE same operands -> Zero=0
//  BNE A=B=0x1234 -> Zero=0
//  reset=0 during SRL shift cycle 2 -> busy=0, done never pulses, ALUResult=0
//  Back-to-back: start in done cycle -> second done exactly 1 cycle later (non-shift)

Source files
------------

// File: rtl/iterative_alu.sv
`default_nettype none
// ============================================================================
// Module   : iterative_alu
// Brief    : EX-stage ALU; single-cycle logic/arith/branch ops, bit-serial shifts.
// Revision : 1.0 - initial release
// ============================================================================
module iterative_alu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero
);
    localparam int SHW = $clog2(DATA_WIDTH);

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_XOR = 4'b0001;
    localparam logic [3:0] c_OP_OR  = 4'b0011;
    localparam logic [3:0] c_OP_ADD = 4'b0100;
    localparam logic [3:0] c_OP_SUB = 4'b0010;
    localparam logic [3:0] c_OP_SLL = 4'b1001;
    localparam logic [3:0] c_OP_SRL = 4'b1100;
    localparam logic [3:0] c_OP_SRA = 4'b0111;
    localparam logic [3:0] c_OP_SLT = 4'b1110;
    localparam logic [3:0] c_OP_LUI = 4'b1010;
    localparam logic [3:0] c_OP_BEQ = 4'b1000;
    localparam logic [3:0] c_OP_BNE = 4'b0110;
    localparam logic [3:0] c_OP_BLT = 4'b1101;
    localparam logic [3:0] c_OP_BGE = 4'b0101;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                r_state;
    logic [3:0]            r_op;
    logic [DATA_WIDTH-1:0] r_work;
    logic [SHW-1:0]        r_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_zero;

    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_zero;
    logic                  w_is_shift;
    logic [SHW-1:0]        w_shamt;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic                  w_lt;

    assign w_shamt    = SrcB[SHW-1:0];
    assign w_is_shift = (Operation == c_OP_SLL) || (Operation == c_OP_SRL) ||
                        (Operation == c_OP_SRA);
    assign w_lt       = $signed(SrcA) < $signed(SrcB);

    // Single-cycle ops; a shift by zero lands here and simply passes A through.
    always_comb begin
        w_result = '0;
        w_zero   = 1'b0;
        case (Operation)
            c_OP_AND: w_result = SrcA & SrcB;
            c_OP_XOR: w_result = SrcA ^ SrcB;
            c_OP_OR:  w_result = SrcA | SrcB;
            c_OP_ADD: w_result = SrcA + SrcB;
            c_OP_SUB: w_result = SrcA - SrcB;
            c_OP_SLL, c_OP_SRL, c_OP_SRA: w_result = SrcA;
            c_OP_SLT: w_result = {{(DATA_WIDTH-1){1'b0}}, w_lt};
            c_OP_LUI: w_result = SrcB;
            c_OP_BEQ: w_result = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
            c_OP_BNE: w_result = {{(DATA_WIDTH-1){1'b0}}, (SrcA != SrcB)};
            c_OP_BLT: w_result = {{(DATA_WIDTH-1){1'b0}}, w_lt};
            c_OP_BGE: w_result = {{(DATA_WIDTH-1){1'b0}}, ~w_lt};
            default:  w_result = '0;
        endcase
        case (Operation)
            c_OP_BEQ, c_OP_BNE, c_OP_BLT, c_OP_BGE: w_zero = w_result[0];
            default:                                w_zero = (w_result == '0);
        endcase
    end

    always_comb begin
        w_shifted = r_work;
        case (r_op)
            c_OP_SLL: w_shifted = {r_work[DATA_WIDTH-2:0], 1'b0};
            c_OP_SRL: w_shifted = {1'b0, r_work[DATA_WIDTH-1:1]};
            c_OP_SRA: w_shifted = {r_work[DATA_WIDTH-1], r_work[DATA_WIDTH-1:1]};
            default:  w_shifted = r_work;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_work   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_is_shift && (w_shamt != '0)) begin
                            r_work  <= SrcA;
                            r_op    <= Operation;
                            r_cnt   <= w_shamt;
                            r_busy  <= 1'b1;
                            r_state <= S_SHIFT;
                        end else begin
                            r_result <= w_result;
                            r_zero   <= w_zero;
                            r_done   <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    r_work <= w_shifted;
                    r_cnt  <= r_cnt - SHW'(1);
                    // Last step: the shifted value is final, complete now.
                    if (r_cnt == SHW'(1)) begin
                        r_result <= w_shifted;
                        r_zero   <= (w_shifted == '0);
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign ALUResult = r_result;
    assign Zero      = r_zero;
endmodule
`default_nettype wire
